// File: rtl/dmem_arbiter.sv
// Two-requester round-robin front end for the data memory: one transaction at a time,
// sub-word stores as read-modify-write, sub-word load extraction, misalignment rejection.
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [1:0]      i_req_valid,
   output logic [1:0]      o_req_ready,
   input  logic [1:0]      i_req_we,
   input  logic [3:0]      i_req_size,
   input  logic [2*AW-1:0] i_req_addr,
   input  logic [2*DW-1:0] i_req_wdata,
   output logic [1:0]      o_rsp_valid,
   output logic [DW-1:0]   o_rsp_rdata,
   output logic            o_rsp_err,
   output logic            o_busy,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic            o_mem_wen,
   output logic            o_mem_ren,
   input  logic [DW-1:0]   i_mem_rdata
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RMW_RD, S_RMW_WAIT, S_RMW_WR, S_ERR
   } state_t;

   state_t          state, state_nxt;
   logic            last_grant;
   logic            grant_id;
   logic            accept;
   logic            sel_we;
   logic [1:0]      sel_size;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            misaligned;

   logic            cur_id;
   logic            cur_we;
   logic [1:0]      cur_size;
   logic [AW-1:0]   cur_addr;
   logic [DW-1:0]   cur_wdata;
   logic [DW-1:0]   merged;

   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;

   function automatic logic [DW-1:0] extract(input logic [DW-1:0] word, input logic [1:0] size,
                                             input logic [1:0] off);
      logic [DW-1:0] sh;
      logic [DW-1:0] res;
      res = word;
      sh  = '0;
      case (size)
         SZ_BYTE: begin
            sh  = word >> {off, 3'b000};
            res = {{(DW-8){1'b0}}, sh[7:0]};
         end
         SZ_HALF: begin
            sh  = word >> {off[1], 4'b0000};
            res = {{(DW-16){1'b0}}, sh[15:0]};
         end
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] word, input logic [DW-1:0] wd,
                                           input logic [1:0] size, input logic [1:0] off);
      logic [DW-1:0] mask;
      logic [DW-1:0] data;
      case (size)
         SZ_BYTE: begin
            mask = {{(DW-8){1'b0}}, 8'hFF} << {off, 3'b000};
            data = {{(DW-8){1'b0}}, wd[7:0]} << {off, 3'b000};
         end
         SZ_HALF: begin
            mask = {{(DW-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
            data = {{(DW-16){1'b0}}, wd[15:0]} << {off[1], 4'b0000};
         end
         default: begin
            mask = '1;
            data = wd;
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

   // Round-robin: on contention the requester that did not win last time goes first.
   always_comb begin
      grant_id = 1'b0;
      if (i_req_valid == 2'b11) grant_id = ~last_grant;
      else if (i_req_valid[1])  grant_id = 1'b1;
   end

   assign accept      = i_rst_n && (state == S_IDLE) && (i_req_valid != 2'b00);
   assign o_req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

   assign sel_we    = i_req_we[grant_id];
   assign sel_size  = grant_id ? i_req_size[3:2]           : i_req_size[1:0];
   assign sel_addr  = grant_id ? i_req_addr[2*AW-1:AW]     : i_req_addr[AW-1:0];
   assign sel_wdata = grant_id ? i_req_wdata[2*DW-1:DW]    : i_req_wdata[DW-1:0];

   assign misaligned = (sel_size == 2'b11)
                    || ((sel_size == SZ_HALF) && sel_addr[0])
                    || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));

   // NOTE: every signal driven here gets its default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (misaligned)              state_nxt = S_ERR;
               else if (!sel_we)            state_nxt = S_RD;
               else if (sel_size == SZ_WORD) state_nxt = S_WR;
               else                         state_nxt = S_RMW_RD;
            end
         end
         S_RD:       state_nxt = S_RD_WAIT;
         S_RD_WAIT:  state_nxt = S_IDLE;
         S_WR:       state_nxt = S_IDLE;
         S_RMW_RD:   state_nxt = S_RMW_WAIT;
         S_RMW_WAIT: state_nxt = S_RMW_WR;
         S_RMW_WR:   state_nxt = S_IDLE;
         S_ERR:      state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (accept) last_grant <= grant_id;
      end
   end

   // NOTE: payload registers carry no reset; they are only consumed in states entered after a load.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         cur_id    <= grant_id;
         cur_we    <= sel_we;
         cur_size  <= sel_size;
         cur_addr  <= sel_addr;
         cur_wdata <= sel_wdata;
      end
      if (state == S_RMW_WAIT) merged <= merge(i_mem_rdata, cur_wdata, cur_size, cur_addr[1:0]);
   end

   // Response pulse is registered on the edge leaving a terminal state; reset drops it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            S_RD_WAIT: begin
               rsp_valid <= cur_id ? 2'b10 : 2'b01;
               rsp_rdata <= cur_we ? '0 : extract(i_mem_rdata, cur_size, cur_addr[1:0]);
            end
            S_WR, S_RMW_WR: rsp_valid <= cur_id ? 2'b10 : 2'b01;
            S_ERR: begin
               rsp_valid <= cur_id ? 2'b10 : 2'b01;
               rsp_err   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_rsp_valid = rsp_valid;
   assign o_rsp_rdata = rsp_rdata;
   assign o_rsp_err   = rsp_err;
   assign o_busy      = (state != S_IDLE);

   assign o_mem_ren   = (state == S_RD) || (state == S_RMW_RD);
   assign o_mem_wen   = (state == S_WR) || (state == S_RMW_WR);
   assign o_mem_addr  = (o_mem_ren || o_mem_wen) ? {cur_addr[AW-1:2], 2'b00} : '0;
   assign o_mem_wdata = (state == S_WR)     ? cur_wdata :
                        (state == S_RMW_WR) ? merged    : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic scored
// against a byte-array memory model and a transaction-level latency/arbitration model.
module tb_dmem_arbiter;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [1:0]  i_req_valid;
   logic [1:0]  o_req_ready;
   logic [1:0]  i_req_we;
   logic [3:0]  i_req_size;
   logic [63:0] i_req_addr;
   logic [63:0] i_req_wdata;
   logic [1:0]  o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_busy;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_mem_wen;
   logic        o_mem_ren;
   logic [31:0] i_mem_rdata;

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_busy(o_busy), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Word memory seen by the DUT; unwritten words read a fixed pattern.
   logic [31:0] mem [0:63];
   logic [63:0] mem_wr = '0;

   function automatic logic [31:0] init_word(input logic [5:0] idx);
      return (({26'b0, idx} + 32'd1) * 32'h9E3779B9) ^ 32'hA5C31E0F;
   endfunction

   function automatic logic [31:0] rd_word(input logic [5:0] idx);
      return mem_wr[idx] ? mem[idx] : init_word(idx);
   endfunction

   always @(posedge i_clk) begin
      if (o_mem_wen) begin
         mem[o_mem_addr[7:2]]    <= o_mem_wdata;
         mem_wr[o_mem_addr[7:2]] <= 1'b1;
      end
      i_mem_rdata <= o_mem_ren ? rd_word(o_mem_addr[7:2]) : $urandom;
   end

   // Strobe monitor.
   int          ren_cnt = 0;
   int          wen_cnt = 0;
   int          viol = 0;
   logic [31:0] last_wdata = '0;
   logic [31:0] last_maddr = '0;
   always @(negedge i_clk) begin
      if (o_mem_ren) ren_cnt <= ren_cnt + 1;
      if (o_mem_wen) begin
         wen_cnt    <= wen_cnt + 1;
         last_wdata <= o_mem_wdata;
      end
      if (o_mem_ren || o_mem_wen) last_maddr <= o_mem_addr;
      if ((o_mem_ren && o_mem_wen) || (!o_mem_wen && o_mem_wdata != 0)
          || (!o_mem_ren && !o_mem_wen && o_mem_addr != 0)
          || ($countones(o_req_ready) > 1) || ($countones(o_rsp_valid) > 1))
         viol <= viol + 1;
   end

   // Reference state.
   logic [7:0]  ref_bytes [0:255];
   logic        ref_last;
   req_t        q0[$];
   req_t        q1[$];
   int          grant_log[$];
   int          acc_log[$];
   int          rsp_log[$];
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      q0.push_back('{we, sz, a, d});
   endtask

   task automatic push1(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      q1.push_back('{we, sz, a, d});
   endtask

   task automatic drive_inputs();
      i_req_valid = {q1.size() != 0, q0.size() != 0};
      i_req_we = 2'b00; i_req_size = 4'b0; i_req_addr = '0; i_req_wdata = '0;
      if (q0.size() != 0) begin
         i_req_we[0] = q0[0].we;   i_req_size[1:0] = q0[0].size;
         i_req_addr[31:0] = q0[0].addr; i_req_wdata[31:0] = q0[0].wdata;
      end
      if (q1.size() != 0) begin
         i_req_we[1] = q1[0].we;   i_req_size[3:2] = q1[0].size;
         i_req_addr[63:32] = q1[0].addr; i_req_wdata[63:32] = q1[0].wdata;
      end
   endtask

   // Transaction-level model: byte-granular memory, latency by transaction kind.
   task automatic ref_txn(input req_t r, output logic [31:0] rd, output logic er, output int lat,
                          output int nren, output int nwen);
      int nb;
      int base;
      er = (r.size == 2'b11) || (r.size == 2'b01 && r.addr[0])
        || (r.size == 2'b10 && r.addr[1:0] != 2'b00);
      rd = '0; nren = 0; nwen = 0; lat = 2;
      if (!er) begin
         nb   = 1 << int'(r.size);
         base = int'(r.addr[7:0]);
         if (r.we) begin
            for (int i = 0; i < nb; i++) ref_bytes[base + i] = r.wdata[8*i +: 8];
            nwen = 1;
            nren = (nb == 4) ? 0 : 1;
            lat  = (nb == 4) ? 2 : 4;
         end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_bytes[base + i];
            nren = 1;
            lat  = 3;
         end
      end
   endtask

   task automatic run(input int budget);
      int          t;
      bit          pend;
      int          due;
      logic        exp_id;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          lat, exp_ren, exp_wen, ren_base, wen_base;
      logic [31:0] exp_maddr;
      logic        win;
      logic [1:0]  vb;
      req_t        r;
      t = 0; pend = 0; due = 0; exp_id = 0; exp_rd = '0; exp_err = 0;
      exp_ren = 0; exp_wen = 0; ren_base = 0; wen_base = 0; exp_maddr = '0;
      grant_log.delete(); acc_log.delete(); rsp_log.delete();
      @(posedge i_clk); #1;
      drive_inputs();
      forever begin
         @(negedge i_clk);
         if (pend && cyc == due) begin
            check("rsp_valid", {30'b0, o_rsp_valid}, exp_id ? 32'd2 : 32'd1);
            check("rsp_rdata", o_rsp_rdata, exp_rd);
            check("rsp_err", {31'b0, o_rsp_err}, {31'b0, exp_err});
            check("ren_count", ren_cnt - ren_base, exp_ren);
            check("wen_count", wen_cnt - wen_base, exp_wen);
            if (exp_ren + exp_wen > 0) check("mem_addr", last_maddr, exp_maddr);
            last_rdata = o_rsp_rdata;
            rsp_log.push_back(cyc);
            pend = 0;
         end else if (o_rsp_valid != 2'b00) begin
            check("stray_rsp", {30'b0, o_rsp_valid}, 32'd0);
         end
         check("busy", {31'b0, o_busy}, {31'b0, pend});
         vb = i_req_valid;
         if (o_req_ready != 2'b00) begin
            if (vb == 2'b00) begin
               check("ready_no_valid", {30'b0, o_req_ready}, 32'd0);
            end else begin
               win = (vb == 2'b11) ? ~ref_last : vb[1];
               check("grant", {30'b0, o_req_ready}, win ? 32'd2 : 32'd1);
               check("accept_idle", {31'b0, pend}, 32'd0);
               if (win) r = q1.pop_front();
               else     r = q0.pop_front();
               ref_txn(r, exp_rd, exp_err, lat, exp_ren, exp_wen);
               exp_maddr = {r.addr[31:2], 2'b00};
               exp_id    = win;
               due       = cyc + lat;
               pend      = 1;
               ren_base  = ren_cnt;
               wen_base  = wen_cnt;
               ref_last  = win;
               grant_log.push_back(int'(win));
               acc_log.push_back(cyc);
            end
         end
         if (!pend && q0.size() == 0 && q1.size() == 0) break;
         @(posedge i_clk); #1;
         drive_inputs();
         t++;
         if (t > budget) begin
            check("timeout", t, budget);
            q0.delete(); q1.delete();
            drive_inputs();
            break;
         end
      end
   endtask

   task automatic rand_req(output req_t r);
      r.we    = 1'($urandom_range(0, 1));
      r.size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r.addr  = 32'($urandom_range(0, 255));
      r.wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
         if (r.size == 2'b01) r.addr[0]   = 1'b0;
         if (r.size == 2'b10) r.addr[1:0] = 2'b00;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   wb;
      req_t r;
      for (int w = 0; w < 64; w++)
         for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = init_word(6'(w)) >> (8*b);
      last_rdata = '0;
      ref_last   = 1'b1;

      // Reset with both requesters asserting valid: nothing may be accepted.
      i_rst_n = 1'b0;
      drive_inputs();
      i_req_valid = 2'b11;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_ready", {30'b0, o_req_ready}, 32'd0);
      check("rst_rsp_valid", {30'b0, o_rsp_valid}, 32'd0);
      check("rst_busy", {31'b0, o_busy}, 32'd0);
      check("rst_strobes", {30'b0, o_mem_ren, o_mem_wen}, 32'd0);
      check("rst_mem_addr", o_mem_addr, 32'd0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      i_req_valid = 2'b00;

      // Word store then load.
      push0(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
      run(20);
      push0(1'b0, 2'b10, 32'h10, 32'h0);
      run(20);
      check("t1_load", last_rdata, 32'hDEADBEEF);

      // Byte store via read-modify-write, then half load.
      push0(1'b1, 2'b10, 32'h10, 32'h11223344);
      push0(1'b1, 2'b00, 32'h12, 32'h000000AB);
      run(30);
      check("t2_merged_word", last_wdata, 32'h11AB3344);
      push0(1'b0, 2'b01, 32'h12, 32'h0);
      run(20);
      check("t2_half_load", last_rdata, 32'h000011AB);

      // Misaligned and illegal-size accesses from requester 1.
      push1(1'b0, 2'b10, 32'h13, 32'h0);
      push1(1'b0, 2'b01, 32'h11, 32'h0);
      push1(1'b0, 2'b11, 32'h10, 32'h0);
      push1(1'b1, 2'b10, 32'h22, 32'h5);
      run(30);

      // Back-to-back: load accepted in the store's response cycle.
      push0(1'b1, 2'b10, 32'h20, 32'hCAFEF00D);
      push0(1'b0, 2'b10, 32'h20, 32'h0);
      run(20);
      check("b2b_accept_cycle", acc_log[1], rsp_log[0]);
      check("b2b_load", last_rdata, 32'hCAFEF00D);

      // Reset while waiting for the RMW read data.
      @(posedge i_clk); #1;
      push0(1'b1, 2'b00, 32'h11, 32'h00000055);
      drive_inputs();
      @(negedge i_clk);
      check("rmw_rst_ready", {30'b0, o_req_ready}, 32'd1);
      wb = wen_cnt;
      void'(q0.pop_front());
      @(posedge i_clk); #1;
      drive_inputs();
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("rmw_rst_busy_before", {31'b0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n  = 1'b1;
      ref_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         check("rmw_rst_no_rsp", {30'b0, o_rsp_valid}, 32'd0);
         check("rmw_rst_idle", {31'b0, o_busy}, 32'd0);
      end
      check("rmw_rst_no_wen", wen_cnt - wb, 32'd0);

      // Continuous contention with loads: grants alternate starting at requester 0.
      for (int i = 0; i < 4; i++) begin
         push0(1'b0, 2'b10, 32'h10, 32'h0);
         push1(1'b0, 2'b10, 32'h20, 32'h0);
      end
      run(60);
      check("rr_grant_count", grant_log.size(), 32'd8);
      for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);

      push0(1'b0, 2'b10, 32'h10, 32'h0);
      run(20);
      check("rmw_rst_readback", last_rdata, 32'h11AB3344);

      // Random traffic from both requesters.
      for (int it = 0; it < 60; it++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            rand_req(r);
            q0.push_back(r);
         end
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            rand_req(r);
            q1.push_back(r);
         end
         run(100);
      end

      @(negedge i_clk);
      check("strobe_rules", viol, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
